// File: rtl/lca_pkg.sv
// Shared definitions for the LM/SM sequencer: opcodes, FSM state encoding
// and instruction field positions of the 16-bit ISA.
package lca_pkg;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_e;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RA_MSB   = 11;
  localparam int RA_LSB   = 9;
  localparam int MASK_MSB = 7;
  localparam int MASK_LSB = 0;

  function automatic logic is_lmsm(input logic [3:0] opc);
    return (opc == OP_LM) || (opc == OP_SM);
  endfunction

endpackage

// File: rtl/lmsm_sequencer_prio_enc8.sv
// Lowest-set-bit priority encoder: returns the index of the least
// significant 1 in an 8-bit vector plus a flag that any bit was set.
module prio_enc8 (
  input  logic [7:0] vec,
  output logic [2:0] idx,
  output logic       found
);

  // Scan downward so the lowest set bit is the final assignment.
  always_comb begin
    idx   = 3'd0;
    found = |vec;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// Expands LM/SM instructions into one memory micro-op per mask bit and passes
// other instructions through with one cycle of latency. Optional seq_cycles
// counter is built when LMSM_PERF_CNT_EN is defined.
module lmsm_sequencer
  import lca_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [15:0] ir_in,
  input  logic        stall_in,
  input  logic        flush,
  output logic        hold_upstream,
  output logic        uop_valid,
  output logic [15:0] uop_ir,
  output logic        uop_mem,
  output logic [2:0]  uop_reg,
  output logic [2:0]  uop_offset,
  output logic        uop_last,
`ifdef LMSM_PERF_CNT_EN
  output logic [15:0] seq_cycles,
`endif
  output state_e      dbg_state
);

  // Handshake: ir_in is consumed on a rising edge where valid_in=1,
  // stall_in=0, flush=0 and hold_upstream=0; upstream keeps the same
  // instruction on ir_in while hold_upstream is high. uop_* is meaningful
  // only when uop_valid=1 and is frozen while stall_in=1.

  state_e      state;
  logic [7:0]  pm;
  logic [15:0] ir_q;
  logic [2:0]  cnt;

  logic [7:0]  enc_in;
  logic [2:0]  enc_idx;
  logic        enc_found;
  logic [7:0]  enc_rest;
  logic        in_lmsm;

  // One encoder serves both the first transfer (fresh mask) and SEQ (pending mask).
  assign enc_in   = (state == SEQ) ? pm : ir_in[MASK_MSB:MASK_LSB];
  assign enc_rest = enc_in & ~(8'd1 << enc_idx);
  assign in_lmsm  = is_lmsm(ir_in[OPC_MSB:OPC_LSB]);

  prio_enc8 u_prio_enc8 (
    .vec   (enc_in),
    .idx   (enc_idx),
    .found (enc_found)
  );

  assign hold_upstream = stall_in | (state == SEQ);
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pm         <= '0;
      ir_q       <= '0;
      cnt        <= '0;
      uop_valid  <= 1'b0;
      uop_ir     <= '0;
      uop_mem    <= 1'b0;
      uop_reg    <= '0;
      uop_offset <= '0;
      uop_last   <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      pm         <= '0;
      cnt        <= '0;
      uop_valid  <= 1'b0;
      uop_ir     <= '0;
      uop_mem    <= 1'b0;
      uop_reg    <= '0;
      uop_offset <= '0;
      uop_last   <= 1'b0;
    end else if (!stall_in) begin
      case (state)
        IDLE: begin
          if (!valid_in) begin
            uop_valid <= 1'b0;
          end else if (!in_lmsm) begin
            uop_valid  <= 1'b1;
            uop_ir     <= ir_in;
            uop_mem    <= 1'b0;
            uop_reg    <= '0;
            uop_offset <= '0;
            uop_last   <= 1'b1;
          end else if (!enc_found) begin
            // Empty mask: instruction retires with no transfer.
            uop_valid <= 1'b0;
          end else begin
            uop_valid  <= 1'b1;
            uop_ir     <= ir_in;
            uop_mem    <= 1'b1;
            uop_reg    <= enc_idx;
            uop_offset <= 3'd0;
            uop_last   <= (enc_rest == 8'd0);
            ir_q       <= ir_in;
            pm         <= enc_rest;
            cnt        <= 3'd1;
            state      <= (enc_rest == 8'd0) ? IDLE : SEQ;
          end
        end
        SEQ: begin
          uop_valid  <= 1'b1;
          uop_ir     <= ir_q;
          uop_mem    <= 1'b1;
          uop_reg    <= enc_idx;
          uop_offset <= cnt;
          uop_last   <= (enc_rest == 8'd0);
          pm         <= enc_rest;
          cnt        <= cnt + 3'd1;
          state      <= (enc_rest == 8'd0) ? IDLE : SEQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LMSM_PERF_CNT_EN
  // Counts unstalled SEQ cycles; deliberately survives flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_cycles <= '0;
    end else if ((state == SEQ) && !stall_in && (seq_cycles != 16'hFFFF)) begin
      seq_cycles <= seq_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: directed scenarios then random traffic, checked
// against a transfer-list model of LM/SM expansion.
module tb_lmsm_sequencer;
  import lca_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [15:0] ir_in = '0;
  logic        stall_in = 1'b0;
  logic        flush = 1'b0;
  logic        hold_upstream;
  logic        uop_valid;
  logic [15:0] uop_ir;
  logic        uop_mem;
  logic [2:0]  uop_reg;
  logic [2:0]  uop_offset;
  logic        uop_last;
  state_e      dbg_state;
`ifdef LMSM_PERF_CNT_EN
  logic [15:0] seq_cycles;
`endif

  always #5 clk = ~clk;

  lmsm_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .ir_in         (ir_in),
    .stall_in      (stall_in),
    .flush         (flush),
    .hold_upstream (hold_upstream),
    .uop_valid     (uop_valid),
    .uop_ir        (uop_ir),
    .uop_mem       (uop_mem),
    .uop_reg       (uop_reg),
    .uop_offset    (uop_offset),
    .uop_last      (uop_last),
`ifdef LMSM_PERF_CNT_EN
    .seq_cycles    (seq_cycles),
`endif
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  // Pending transfers of the instruction being expanded: {ir, reg, offset, last}.
  logic [22:0] exp_q[$];

  logic        e_valid = 1'b0;
  logic [15:0] e_ir    = '0;
  logic        e_mem   = 1'b0;
  logic [2:0]  e_reg   = '0;
  logic [2:0]  e_off   = '0;
  logic        e_last  = 1'b0;
  int          e_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    e_valid = 1'b0; e_ir = '0; e_mem = 1'b0; e_reg = '0; e_off = '0; e_last = 1'b0;
  endtask

  // Builds the transfer list straight from the mask: one entry per set bit, ascending.
  task automatic expand(input logic [15:0] ir);
    int k;
    k = 0;
    for (int r = 0; r < 8; r++) begin
      if (ir[r]) begin
        exp_q.push_back({ir, 3'(r), 3'(k), 1'b0});
        k++;
      end
    end
    if (k > 0) exp_q[k-1][0] = 1'b1;
  endtask

  task automatic compare_outputs(input string tag);
    check({tag, ".valid"}, 32'(uop_valid), 32'(e_valid));
    check({tag, ".ir"},    32'(uop_ir),    32'(e_ir));
    check({tag, ".mem"},   32'(uop_mem),   32'(e_mem));
    check({tag, ".reg"},   32'(uop_reg),   32'(e_reg));
    check({tag, ".off"},   32'(uop_offset),32'(e_off));
    check({tag, ".last"},  32'(uop_last),  32'(e_last));
    check({tag, ".state"}, 32'(dbg_state), 32'(exp_q.size() != 0));
`ifdef LMSM_PERF_CNT_EN
    check({tag, ".cycles"}, 32'(seq_cycles), 32'(e_cycles));
`endif
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic v, input logic [15:0] ir,
                      input logic st, input logic fl);
    logic        busy;
    logic [22:0] x;
    @(negedge clk);
    valid_in = v; ir_in = ir; stall_in = st; flush = fl;
    #1;
    busy = (exp_q.size() != 0);
    check({tag, ".hold"}, 32'(hold_upstream), 32'(st | busy));
    if (busy && !st && e_cycles < 65535) e_cycles++;
    if (fl) begin
      model_clear();
    end else if (!st) begin
      if (!busy && v && !is_lmsm(ir[15:12])) begin
        e_valid = 1'b1; e_ir = ir; e_mem = 1'b0; e_reg = '0; e_off = '0; e_last = 1'b1;
      end else begin
        if (!busy && v) expand(ir);
        if (exp_q.size() != 0) begin
          x = exp_q.pop_front();
          e_valid = 1'b1; e_mem = 1'b1;
          {e_ir, e_reg, e_off, e_last} = x;
        end else begin
          e_valid = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    int sel;
    w = 16'($urandom);
    sel = $urandom_range(0, 3);
    if (sel == 0) w[15:12] = OP_LM;
    else if (sel == 1) w[15:12] = OP_SM;
    else if (is_lmsm(w[15:12])) w[15:12] = 4'h1;
    sel = $urandom_range(0, 4);
    if (sel == 0) w[7:0] = 8'h00;
    else if (sel == 1) w[7:0] = 8'(8'd1 << $urandom_range(0, 7));
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    #2;
    compare_outputs("reset");
    check("reset.hold", 32'(hold_upstream), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    step("add", 1'b1, 16'h1050, 1'b0, 1'b0);
    step("idle", 1'b0, 16'h0000, 1'b0, 1'b0);

    // LM R3, mask 1010_0101
    step("lm0", 1'b1, 16'h66A5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("lm", 1'b1, 16'h2222, 1'b0, 1'b0);
    step("lm_next", 1'b0, 16'h0000, 1'b0, 1'b0);

    // SM single bit, then immediately another instruction
    step("sm80", 1'b1, 16'h7080, 1'b0, 1'b0);
    step("sm_next", 1'b1, 16'h1234, 1'b0, 1'b0);

    // Empty mask LM then ADD
    step("lm00", 1'b1, 16'h6000, 1'b0, 1'b0);
    step("lm00_add", 1'b1, 16'h1050, 1'b0, 1'b0);

    // Mask FF with stall during the second transfer
    step("ff0", 1'b1, 16'h60FF, 1'b0, 1'b0);
    step("ff1", 1'b1, 16'h60FF, 1'b0, 1'b0);
    step("ff_st", 1'b1, 16'h60FF, 1'b1, 1'b0);
    step("ff_st", 1'b1, 16'h60FF, 1'b1, 1'b0);
    check("ff_st.reg", 32'(uop_reg), 32'd1);
    check("ff_st.off", 32'(uop_offset), 32'd1);
    for (int i = 0; i < 6; i++) step("ff", 1'b0, 16'h0000, 1'b0, 1'b0);
    step("ff_end", 1'b0, 16'h0000, 1'b0, 1'b0);

    // Flush together with stall mid-sequence
    step("fl0", 1'b1, 16'h7F0F, 1'b0, 1'b0);
    step("fl1", 1'b0, 16'h0000, 1'b0, 1'b0);
    step("flush", 1'b0, 16'h0000, 1'b1, 1'b1);
    step("post_fl", 1'b1, 16'h3456, 1'b0, 1'b0);

    // Asynchronous reset mid-sequence
    step("rs0", 1'b1, 16'h60F0, 1'b0, 1'b0);
    step("rs1", 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    valid_in = 1'b0; stall_in = 1'b0; flush = 1'b0;
    #2;
    check("pre_rst.hold", 32'(hold_upstream), 32'd1);
    reset = 1'b0;
    #1;
    check("rst.hold", 32'(hold_upstream), 32'd0);
    model_clear();
    e_cycles = 0;
    compare_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step("rnd", ($urandom_range(0, 3) != 0), rand_instr(),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 24) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
